// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared state encoding and default widths for the PWM tone player.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int c_PHASE_WIDTH = 32;
    localparam int c_PWM_WIDTH   = 8;
    localparam int c_ENV_DIV     = 65536;

    typedef enum logic [1:0] {
        ST_REST = 2'd0,
        ST_PLAY = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_carrier.sv
// ============================================================================
// Module   : pwm_carrier
// Purpose  : PWM carrier counter with glitch-free top staging and gated compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_carrier #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [PWM_WIDTH-1:0] i_top,
    input  logic                 i_top_valid,
    input  logic [PWM_WIDTH:0]   i_level,
    input  logic                 i_gate,
    output logic                 o_pwm,
    output logic                 o_wrap,
    output logic [PWM_WIDTH-1:0] o_top_active
);

    logic [PWM_WIDTH-1:0] r_cnt;
    logic [PWM_WIDTH-1:0] r_top_active;
    logic [PWM_WIDTH-1:0] r_top_pending;
    logic                 r_pend_flag;
    logic                 r_pwm;
    logic                 w_apply;

    // A zero top keeps the counter parked at 0, so apply fires every cycle.
    assign w_apply = (r_cnt == r_top_active);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_top_active  <= '0;
            r_top_pending <= '0;
            r_pend_flag   <= 1'b0;
            r_pwm         <= 1'b0;
        end else begin
            r_pwm <= i_gate & ({1'b0, r_cnt} < i_level);
            if (w_apply) begin
                r_cnt       <= '0;
                r_pend_flag <= 1'b0;
                if (i_top_valid) begin
                    r_top_active  <= i_top;
                    r_top_pending <= i_top;
                end else if (r_pend_flag) begin
                    r_top_active <= r_top_pending;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (i_top_valid) begin
                    r_top_pending <= i_top;
                    r_pend_flag   <= 1'b1;
                end
            end
        end
    end

    assign o_pwm        = r_pwm;
    assign o_wrap       = w_apply;
    assign o_top_active = r_top_active;

endmodule

`default_nettype wire

// File: rtl/pwm_tone_player.sv
// ============================================================================
// Module   : pwm_tone_player
// Purpose  : NCO square-wave tone gated onto a PWM carrier, click-free note
//            changes at accumulator wrap. Optional decaying envelope enabled
//            by defining PWM_TONE_PLAYER_ENVELOPE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_tone_player
    import pwm_pkg::*;
#(
    parameter int PHASE_WIDTH = c_PHASE_WIDTH,
    parameter int PWM_WIDTH   = c_PWM_WIDTH,
    parameter int ENV_DIV     = c_ENV_DIV
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [PWM_WIDTH-1:0]   i_top,
    input  logic                   i_top_valid,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    output logic                   o_pwm,
    output logic                   o_tone,
    output logic                   o_note_start,
    output logic                   o_resting
);

    state_t                 r_state, w_state_nx;
    logic [PHASE_WIDTH-1:0] r_acc, w_acc_nx, w_acc_sum;
    logic [PHASE_WIDTH-1:0] r_delta_active, w_delta_active_nx;
    logic [PHASE_WIDTH-1:0] r_delta_pending, w_delta_pending_nx;
    logic                   r_tone, r_note_start, w_note_start_nx;
    logic                   w_carry;
    logic [PWM_WIDTH:0]     w_level;
    logic [PWM_WIDTH-1:0]   w_top_active;
    logic                   w_carrier_wrap;
    logic                   w_unused_wrap;

    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, r_delta_active};

    always_comb begin
        w_state_nx         = r_state;
        w_acc_nx           = w_acc_sum;
        w_delta_active_nx  = r_delta_active;
        w_delta_pending_nx = r_delta_pending;
        w_note_start_nx    = 1'b0;
        case (r_state)
            ST_REST: begin
                w_acc_nx = '0;
                if (i_phase_delta != '0) begin
                    w_delta_active_nx = i_phase_delta;
                    w_note_start_nx   = 1'b1;
                    w_state_nx        = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_phase_delta != r_delta_active) begin
                    w_delta_pending_nx = i_phase_delta;
                    w_state_nx         = ST_PEND;
                end
            end
            ST_PEND: begin
                w_delta_pending_nx = i_phase_delta;
                // A withdrawn change takes priority over a coincident wrap.
                if (i_phase_delta == r_delta_active) begin
                    w_state_nx = ST_PLAY;
                end else if (w_carry) begin
                    if (r_delta_pending != '0) begin
                        w_delta_active_nx = r_delta_pending;
                        w_note_start_nx   = 1'b1;
                        w_state_nx        = ST_PLAY;
                    end else begin
                        w_acc_nx          = '0;
                        w_delta_active_nx = '0;
                        w_state_nx        = ST_REST;
                    end
                end
            end
            default: w_state_nx = ST_REST;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_REST;
            r_acc           <= '0;
            r_delta_active  <= '0;
            r_delta_pending <= '0;
            r_tone          <= 1'b0;
            r_note_start    <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_acc           <= w_acc_nx;
            r_delta_active  <= w_delta_active_nx;
            r_delta_pending <= w_delta_pending_nx;
            r_tone          <= w_acc_nx[PHASE_WIDTH-1];
            r_note_start    <= w_note_start_nx;
        end
    end

`ifdef PWM_TONE_PLAYER_ENVELOPE_EN
    localparam int c_DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(ENV_DIV - 1);

    logic [c_DIV_W-1:0]   r_div;
    logic [PWM_WIDTH:0]   r_level;
    logic [PWM_WIDTH-1:0] r_top_seen;
    logic [PWM_WIDTH:0]   w_level_max;

    assign w_level_max = {1'b0, w_top_active} + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div      <= '0;
            r_level    <= '0;
            r_top_seen <= '0;
        end else begin
            r_top_seen <= w_top_active;
            if (r_state == ST_REST) begin
                r_div   <= '0;
                r_level <= '0;
            end else if (r_note_start) begin
                r_div   <= '0;
                r_level <= w_level_max;
            end else if ((w_top_active != r_top_seen) && (r_level > w_level_max)) begin
                r_level <= w_level_max;
            end else if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                if (r_level != '0) begin
                    r_level <= r_level - 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign w_level = r_level;
`else
    logic w_unused_env;

    assign w_unused_env = (ENV_DIV == 0);
    assign w_level      = ({1'b0, w_top_active} + 1'b1) >> 1;
`endif

    pwm_carrier #(
        .PWM_WIDTH (PWM_WIDTH)
    ) u_carrier (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_top        (i_top),
        .i_top_valid  (i_top_valid),
        .i_level      (w_level),
        .i_gate       (r_tone),
        .o_pwm        (o_pwm),
        .o_wrap       (w_carrier_wrap),
        .o_top_active (w_top_active)
    );

    assign w_unused_wrap = w_carrier_wrap;
    assign o_tone        = r_tone;
    assign o_note_start  = r_note_start;
    assign o_resting     = (r_state == ST_REST);

endmodule

`default_nettype wire

// File: doc/pwm_tone_player.md
Name: pwm_tone_player

Overview:
Consumer end of the note-sequencer interface. Takes a PWM carrier top (with valid strobe) and a continuously driven NCO phase delta, runs a phase accumulator to make a square-wave tone, and gates a PWM carrier with it to drive the speaker pin. Note changes are applied only at waveform zero crossings (accumulator wrap) so they are click-free. A phase delta of 0 is a rest.

Parameters:
PHASE_WIDTH, 32, accumulator and phase-delta width
PWM_WIDTH, 8, carrier counter and top width
ENV_DIV, 65536, clocks per envelope decay step (used only with the optional envelope)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_top  in  PWM_WIDTH  carrier top; carrier period = top+1 clocks
i_top_valid  in  1  qualifies i_top; sampled every cycle
i_phase_delta  in  PHASE_WIDTH  per-clock accumulator increment; 0 = rest
o_pwm  out  1  speaker drive
o_tone  out  1  raw square tone (registered accumulator MSB)
o_note_start  out  1  one-cycle pulse when a new nonzero delta becomes active
o_resting  out  1  high while in REST

Behaviour:
- Reset (i_rst high at posedge): acc=0, delta_active=0, delta_pending=0, top_active=0, top_pending=0, top_pend_flag=0, pwm_cnt=0, level=0, state=REST. All outputs 0, except o_resting=1. A mid-operation reset takes effect at the next edge and discards pending updates.
- Carrier:
  - pwm_cnt counts 0..top_active, then wraps to 0.
  - If top_active==0, pwm_cnt stays 0.
  - o_pwm = o_tone & (pwm_cnt < level), registered with 1-cycle latency.
  - level is PWM_WIDTH+1 bits. Without the envelope, level = (top_active+1)>>1.
- Top update:
  - i_top_valid loads top_pending and sets top_pend_flag. The last valid wins if several arrive before apply.
  - Apply on the cycle pwm_cnt==top_active, or immediately when top_active==0: top_active<=top_pending, pwm_cnt<=0, flag cleared.
  - If valid and apply fall in the same cycle, the incoming i_top is applied directly.
- Accumulator: acc <= acc + delta_active (modulo 2^PHASE_WIDTH). carry = carry-out of that add. o_tone <= acc_next MSB.
- State machine:
  - REST: acc held at 0, o_tone=0.
    - i_phase_delta != 0 → delta_active<=i_phase_delta, o_note_start=1 next cycle, go to PLAY.
  - PLAY: i_phase_delta != delta_active → delta_pending<=i_phase_delta, go to PEND.
  - PEND: delta_pending tracks i_phase_delta every cycle.
    - i_phase_delta == delta_active (change withdrawn) → PLAY, no pulse.
    - On carry, apply delta_pending:
      - nonzero → delta_active<=delta_pending, o_note_start pulse, go to PLAY; acc keeps its post-wrap residue (phase continuous).
      - zero → acc<=0, delta_active<=0, go to REST.
    - Carry and a withdrawn change in the same cycle: the withdrawal wins.
- o_note_start is high for exactly the one cycle after delta_active changes to a nonzero value. A rest-to-same-note restart does pulse.

Optional Feature:
PWM_TONE_PLAYER_ENVELOPE_EN
- Defined: on each o_note_start, level <= top_active+1. A divider counts ENV_DIV clocks; each expiry decrements level, floored at 0.
  - Divider reset on note start and on i_rst. level=0 in REST.
  - A top change clamps level to the new top_active+1.
- Undefined: level = (top_active+1)>>1 combinationally; no divider logic is present.

Decomposition:
- Shared package pwm_pkg: state encoding (REST=2'd0, PLAY=2'd1, PEND=2'd2), default widths, ENV_DIV default.
- One natural sub-module, pwm_carrier: counter, top staging and compare, with inputs top/valid/level/gate and outputs pwm plus a wrap strobe.
- Accumulator and FSM stay in the top module.

Test Plan:
- Reset, then i_phase_delta=0, i_top=8'hFF valid → o_resting=1, o_tone=0, o_pwm=0 for 1000 cycles.
- delta=32'h8000_0000 from REST → o_note_start pulses once one cycle after apply; o_tone toggles every clock (period 2).
- delta=32'h4000_0000 → o_tone period 4. Switch to 32'h2000_0000 mid-cycle → new period takes effect only after the next accumulator wrap; exactly one o_note_start.
- top=3, delta=32'h0800_0000 → while o_tone=1, o_pwm is high 2 of every 4 clocks. Top change to 7 mid-period applies only at pwm_cnt==3.
- In PEND, toggle i_phase_delta away and back before the wrap → no o_note_start, period unchanged. Delta→0 → REST at the next wrap, acc=0.
- ENVELOPE_EN, ENV_DIV=4, top=3 → level steps 4,3,2,1,0 every 4 clocks after o_note_start; i_rst mid-decay → level 0, REST.
